// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: syndrome stage for an RS(7,k) decoder over GF(2^3),
// p(x) = x^3 + x + 1, alpha = 3'd2.
// Received symbols arrive highest degree first, one per din_valid cycle.
// The block evaluates r(x) at alpha^1..alpha^(2T) by Horner accumulation.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        received symbol; the first accepted symbol is r_(N-1)
//   din_valid  din is valid this cycle
//   din_sop    din is the first symbol of a codeword (needs din_valid)
//   synd       packed syndromes, S_j at [3j-1:3(j-1)], S1 in the LSBs
//   synd_valid one-cycle pulse when synd/synd_nz are updated
//   synd_nz    high if any S_j is nonzero
//   busy       frame in progress
//   frame_err  one-cycle pulse when a new sop aborts a frame
//
// State table:
//   IDLE    | waiting for din_sop; din_valid without sop is dropped
//   COLLECT | accumulating symbols 2..N of the current codeword

// General GF(8) multiplier, p(x) = x^3 + x + 1.
module gf8mul_dec (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] p
);
    logic [4:0] prod;

    always_comb begin
        prod = 5'd0;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) prod = prod ^ (5'(a) << i);
        end
        // Fold x^3 -> x + 1 and x^4 -> x^2 + x.
        p = prod[2:0] ^ (prod[3] ? 3'b011 : 3'b000) ^ (prod[4] ? 3'b110 : 3'b000);
    end
endmodule

module rs_syndrome_calc #(
    parameter int N = 7,
    parameter int T = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     din,
    input  logic           din_valid,
    input  logic           din_sop,
    output logic [6*T-1:0] synd,
    output logic           synd_valid,
    output logic           synd_nz,
    output logic           busy,
    output logic           frame_err
);
    localparam int         NS       = 2 * T;
    localparam logic [2:0] CNT_LAST = 3'(N - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    function automatic logic [2:0] alpha_pow(input int j);
        case (j % 7)
            0:       return 3'd1;
            1:       return 3'd2;
            2:       return 3'd4;
            3:       return 3'd3;
            4:       return 3'd6;
            5:       return 3'd7;
            default: return 3'd5;
        endcase
    endfunction

    state_t          state;
    logic [2:0]      cnt;
    logic [3*NS-1:0] acc;
    logic [3*NS-1:0] nxt;

    // Horner step per syndrome: acc_j * alpha^j xor din.
    for (genvar j = 0; j < NS; j++) begin : g_horner
        logic [2:0] prod;
        gf8mul_dec u_mul (
            .a (acc[3*j +: 3]),
            .b (alpha_pow(j + 1)),
            .p (prod)
        );
        assign nxt[3*j +: 3] = prod ^ din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            acc        <= '0;
            synd       <= '0;
            synd_valid <= 1'b0;
            synd_nz    <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            synd_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid && din_sop) begin
                        state <= COLLECT;
                        cnt   <= 3'd1;
                        acc   <= {NS{din}};
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (din_valid) begin
                        if (din_sop) begin
                            // Restart on the new codeword; synd keeps the last result.
                            frame_err <= 1'b1;
                            cnt       <= 3'd1;
                            acc       <= {NS{din}};
                        end else if (cnt == CNT_LAST) begin
                            synd       <= nxt;
                            synd_nz    <= |nxt;
                            synd_valid <= 1'b1;
                            busy       <= 1'b0;
                            cnt        <= 3'd0;
                            acc        <= nxt;
                            state      <= IDLE;
                        end else begin
                            acc <= nxt;
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb_rs_syndrome_calc: directed stimulus for rs_syndrome_calc with a
// scoreboard of expected syndrome results and frame_err pulses, checked by
// an independent monitor on the falling edge.
module tb_rs_syndrome_calc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  din = 3'd0;
    logic        din_valid = 1'b0;
    logic        din_sop = 1'b0;
    logic [11:0] synd;
    logic        synd_valid;
    logic        synd_nz;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] synd;
        logic        nz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          fe_q[$];
    logic [11:0] last_synd = 12'h000;

    rs_syndrome_calc #(.N(7), .T(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .synd       (synd),
        .synd_valid (synd_valid),
        .synd_nz    (synd_nz),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every output event against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   fc;
        if (rst_n) begin
            if (synd_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_synd_valid cyc=%0d synd=%h", cyc, synd);
                end else begin
                    e = sb.pop_front();
                    if (synd !== e.synd || synd_nz !== e.nz || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL synd_result got synd=%h nz=%b cyc=%0d expected synd=%h nz=%b cyc=%0d",
                                 synd, synd_nz, cyc, e.synd, e.nz, e.cyc);
                    end
                    last_synd = e.synd;
                end
            end
            if (frame_err) begin
                checks++;
                if (fe_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame_err cyc=%0d", cyc);
                end else begin
                    fc = fe_q.pop_front();
                    if (cyc != fc || synd !== last_synd) begin
                        failures++;
                        $display("FAIL frame_err got cyc=%0d synd=%h expected cyc=%0d synd=%h",
                                 cyc, synd, fc, last_synd);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic sop, input logic [2:0] d);
        din_valid = v;
        din_sop   = sop;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    // frame holds r6 in [20:18] down to r0 in [2:0].
    task automatic send_frame(input logic [20:0] frame, input logic [11:0] exp_synd,
                              input bit gaps, input bit aborts);
        exp_t e;
        logic [2:0] s;
        for (int i = 0; i < 7; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) drive(1'b0, 1'b0, 3'd7);
            end
            s = frame[20 - 3*i -: 3];
            if (i == 0 && aborts) fe_q.push_back(cyc + 1);
            if (i == 6) begin
                e.synd = exp_synd;
                e.nz   = (exp_synd != 12'h000);
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            drive(1'b1, i == 0, s);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (synd !== 12'h000 || synd_valid !== 1'b0 || synd_nz !== 1'b0 ||
            busy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL %s got synd=%h sv=%b nz=%b busy=%b fe=%b expected all zero",
                     name, synd, synd_valid, synd_nz, busy, frame_err);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    localparam logic [20:0] F_ZERO  = 21'h000000;
    localparam logic [20:0] F_LAST1 = 21'h000001;
    localparam logic [20:0] F_FIRST = 21'h040000;

    initial begin
        #1;
        check_outputs_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0);

        // 1: all-zero codeword
        send_frame(F_ZERO, 12'h000, 0, 0);
        check_bit("busy_after_frame", busy, 1'b0);
        drive(1'b0, 1'b0, 3'd0);

        // 2: only r0 = 1
        send_frame(F_LAST1, 12'h249, 0, 0);
        drive(1'b0, 1'b0, 3'd0);

        // 3: only r6 = 1, without and with gaps
        send_frame(F_FIRST, 12'h7BD, 0, 0);
        drive(1'b0, 1'b0, 3'd0);
        send_frame(F_FIRST, 12'h7BD, 1, 0);
        repeat (3) drive(1'b0, 1'b0, 3'd0);

        // 4: partial frame aborted by a new sop
        drive(1'b1, 1'b1, 3'd5);
        check_bit("busy_in_frame", busy, 1'b1);
        drive(1'b1, 1'b0, 3'd3);
        drive(1'b1, 1'b0, 3'd6);
        drive(1'b1, 1'b0, 3'd1);
        send_frame(F_LAST1, 12'h249, 0, 1);
        repeat (3) drive(1'b0, 1'b0, 3'd0);

        // 5: stray data while idle, then back-to-back frames
        drive(1'b1, 1'b0, 3'd5);
        drive(1'b1, 1'b0, 3'd2);
        check_bit("busy_stray_idle", busy, 1'b0);
        send_frame(F_FIRST, 12'h7BD, 0, 0);
        send_frame(F_LAST1, 12'h249, 0, 0);
        repeat (3) drive(1'b0, 1'b0, 3'd0);

        // 6: reset mid-frame, then a normal frame
        drive(1'b1, 1'b1, 3'd4);
        drive(1'b1, 1'b0, 3'd2);
        drive(1'b1, 1'b0, 3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset_midframe");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_synd = 12'h000;
        drive(1'b0, 1'b0, 3'd0);
        send_frame(F_ZERO, 12'h000, 0, 0);
        repeat (4) drive(1'b0, 1'b0, 3'd0);

        checks++;
        if (sb.size() != 0 || fe_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got synd_left=%0d fe_left=%0d expected 0 and 0",
                     sb.size(), fe_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
